// File: rtl/pwm_freq_ctrl_pkg.sv
// Shared math helper, step-size table and FSM encoding for the PWM frequency control stage.
package pwm_freq_ctrl_pkg;

    // Number of bits needed to represent value (0 -> 0 bits).
    function automatic int CLogB2(input int unsigned value);
        int r;
        r = 0;
        for (int unsigned v = value; v != 0; v = v >> 1) r++;
        return r;
    endfunction

    localparam int unsigned STEP0 = 1;
    localparam int unsigned STEP1 = 10;
    localparam int unsigned STEP2 = 100;
    localparam int unsigned STEP3 = 1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic int unsigned step_size(input logic [1:0] sel);
        int unsigned s;
        case (sel)
            2'd0:    s = STEP0;
            2'd1:    s = STEP1;
            2'd2:    s = STEP2;
            default: s = STEP3;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/pwm_freq_ctrl_seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle: ND cycles from start to done.
// No backpressure: start while active restarts; done is high during the final iteration.
module pwm_freq_ctrl_seq_divider
    import pwm_freq_ctrl_pkg::*;
#(
    parameter int ND = 25,
    parameter int NW = 14
) (
    input  logic          iCLK,
    input  logic          iRST_n,
    input  logic          start,
    input  logic [ND-1:0] dividend,
    input  logic [NW-1:0] divisor,
    output logic          done,
    output logic [ND-1:0] quotient
);

    localparam int CW = (ND > 1) ? CLogB2(ND - 1) : 1;

    // Quotient bits shift into the dividend register as dividend bits shift out.
    logic [ND-1:0] dvd;
    logic [NW-1:0] dvs;
    logic [NW-1:0] rem;
    logic [CW-1:0] cnt;
    logic          active;
    logic [NW:0]   trial;
    logic [NW:0]   diff;
    logic          ge;

    always_comb begin
        trial = {rem, dvd[ND-1]};
        ge    = (trial >= {1'b0, dvs});
        diff  = trial - {1'b0, dvs};
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            dvd    <= '0;
            dvs    <= '0;
            rem    <= '0;
            cnt    <= '0;
            active <= 1'b0;
        end else if (start) begin
            dvd    <= dividend;
            dvs    <= divisor;
            rem    <= '0;
            cnt    <= CW'(ND - 1);
            active <= 1'b1;
        end else if (active) begin
            rem <= ge ? diff[NW-1:0] : trial[NW-1:0];
            dvd <= {dvd[ND-2:0], ge};
            if (cnt == '0) active <= 1'b0;
            else           cnt    <= cnt - 1'b1;
        end
    end

    assign done     = active && (cnt == '0);
    assign quotient = dvd;

endmodule

// File: rtl/pwm_freq_ctrl.sv
// Frequency setpoint from up/down pulses, converted to counter modulus floor(SYSCLK/(2*f)).
// Result ND+2 edges after the command; commands arriving while busy are dropped.
module pwm_freq_ctrl
    import pwm_freq_ctrl_pkg::*;
#(
    parameter int unsigned SYSCLK_FRQ = 50000000,
    parameter int unsigned FREQ_MIN   = 1,
    parameter int unsigned FREQ_MAX   = 10000,
    parameter int          NB_FREQ    = CLogB2(FREQ_MAX),
    parameter int          NB_CONT    = CLogB2(SYSCLK_FRQ / (2 * FREQ_MIN) - 1),
    parameter int          ND         = CLogB2(SYSCLK_FRQ / 2)
) (
    input  logic               iCLK,
    input  logic               iRST_n,
    input  logic               iUP,
    input  logic               iDOWN,
    input  logic [1:0]         iSTEP_SEL,
    output logic [NB_FREQ-1:0] oFREQ,
    output logic [NB_CONT-1:0] oMODULE,
    output logic               oVALID,
    output logic               oBUSY
);

    localparam logic [ND-1:0]      DIVIDEND = ND'(SYSCLK_FRQ / 2);
    localparam logic [NB_CONT-1:0] MOD_RST  = NB_CONT'(SYSCLK_FRQ / (2 * FREQ_MIN));
    localparam logic [NB_FREQ-1:0] F_MIN    = NB_FREQ'(FREQ_MIN);

    state_t            state;
    logic              cmd;
    logic [31:0]       fcur;
    logic [31:0]       step;
    logic [31:0]       nf_wide;
    logic [NB_FREQ-1:0] nf;
    logic              div_start;
    logic              div_done;
    logic [ND-1:0]     quot;

    // 32-bit arithmetic so the saturation tests never see a wrapped value.
    always_comb begin
        cmd     = iUP ^ iDOWN;
        fcur    = 32'(oFREQ);
        step    = step_size(iSTEP_SEL);
        nf_wide = fcur;
        if (iUP && !iDOWN)
            nf_wide = (fcur + step > FREQ_MAX) ? FREQ_MAX : fcur + step;
        else if (iDOWN && !iUP)
            nf_wide = (fcur < FREQ_MIN + step) ? FREQ_MIN : fcur - step;
        nf = nf_wide[NB_FREQ-1:0];
    end

    assign div_start = (state == ST_LOAD);

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state   <= ST_IDLE;
            oFREQ   <= F_MIN;
            oMODULE <= MOD_RST;
            oVALID  <= 1'b0;
            oBUSY   <= 1'b0;
        end else begin
            oVALID <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd && (nf != oFREQ)) begin
                        oFREQ <= nf;
                        oBUSY <= 1'b1;
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: state <= ST_DIV;
                ST_DIV: begin
                    if (div_done) state <= ST_DONE;
                end
                ST_DONE: begin
                    // Modulus only changes here, so the counter never sees a partial quotient.
                    oMODULE <= quot[NB_CONT-1:0];
                    oVALID  <= 1'b1;
                    oBUSY   <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    pwm_freq_ctrl_seq_divider #(
        .ND (ND),
        .NW (NB_FREQ)
    ) u_div (
        .iCLK     (iCLK),
        .iRST_n   (iRST_n),
        .start    (div_start),
        .dividend (DIVIDEND),
        .divisor  (oFREQ),
        .done     (div_done),
        .quotient (quot)
    );

endmodule

// File: tb/tb_pwm_freq_ctrl.sv
// Directed and randomized bench for pwm_freq_ctrl against an arithmetic reference model.
module tb_pwm_freq_ctrl;

    localparam int SYS  = 50000000;
    localparam int FMIN = 1;
    localparam int FMAX = 10000;
    localparam int ND   = 25;

    logic        iCLK = 1'b0;
    logic        iRST_n = 1'b0;
    logic        iUP = 1'b0;
    logic        iDOWN = 1'b0;
    logic [1:0]  iSTEP_SEL = 2'd0;
    logic [13:0] oFREQ;
    logic [24:0] oMODULE;
    logic        oVALID;
    logic        oBUSY;

    int checks = 0;
    int errors = 0;
    int     m_freq;
    longint m_mod;

    pwm_freq_ctrl dut (
        .iCLK      (iCLK),
        .iRST_n    (iRST_n),
        .iUP       (iUP),
        .iDOWN     (iDOWN),
        .iSTEP_SEL (iSTEP_SEL),
        .oFREQ     (oFREQ),
        .oMODULE   (oMODULE),
        .oVALID    (oVALID),
        .oBUSY     (oBUSY)
    );

    always #5 iCLK = ~iCLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_next(input int f, input bit up, input bit dn, input int sel);
        int s;
        s = 10 ** sel;
        if (up == dn) return f;
        if (up) return (f + s > FMAX) ? FMAX : f + s;
        return (f - s < FMIN) ? FMIN : f - s;
    endfunction

    // One command pulse, then follow the transaction; drop_at>0 injects an iUP on that edge.
    task automatic run_cmd(input string tag, input bit up, input bit dn, input int sel, input int drop_at);
        int     nf;
        int     n;
        longint exp_mod;
        longint prev_mod;
        bit     busy_ok;
        bit     mod_stable;
        bit     valid_seen;
        bit     busy_seen;
        nf       = ref_next(m_freq, up, dn, sel);
        prev_mod = m_mod;
        iUP = up; iDOWN = dn; iSTEP_SEL = 2'(sel);
        @(posedge iCLK); #1;
        iUP = 1'b0; iDOWN = 1'b0; iSTEP_SEL = 2'($urandom_range(0, 3));
        chk({tag, " freq"}, oFREQ, nf);
        if (nf != m_freq) begin
            exp_mod = SYS / (2 * nf);
            chk({tag, " busy_set"}, oBUSY, 1);
            busy_ok = 1'b1; mod_stable = 1'b1; n = 0;
            while (oVALID !== 1'b1 && n < 40) begin
                if (n + 1 == drop_at) iUP = 1'b1;
                @(posedge iCLK); #1;
                iUP = 1'b0;
                n++;
                if (oVALID !== 1'b1) begin
                    if (oBUSY !== 1'b1) busy_ok = 1'b0;
                    if (oMODULE !== prev_mod[24:0]) mod_stable = 1'b0;
                end
            end
            chk({tag, " latency"}, n, ND + 2);
            chk({tag, " busy_held"}, busy_ok, 1);
            chk({tag, " module_stable"}, mod_stable, 1);
            chk({tag, " module"}, oMODULE, exp_mod);
            chk({tag, " busy_clr"}, oBUSY, 0);
            chk({tag, " freq_final"}, oFREQ, nf);
            @(posedge iCLK); #1;
            chk({tag, " valid_1cyc"}, oVALID, 0);
            m_freq = nf;
            m_mod  = exp_mod;
        end else begin
            valid_seen = 1'b0; busy_seen = 1'b0;
            repeat (30) begin
                @(posedge iCLK); #1;
                if (oVALID !== 1'b0) valid_seen = 1'b1;
                if (oBUSY !== 1'b0) busy_seen = 1'b1;
            end
            chk({tag, " no_valid"}, valid_seen, 0);
            chk({tag, " no_busy"}, busy_seen, 0);
            chk({tag, " module_kept"}, oMODULE, prev_mod);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        int sel;
        int drop;
        bit up;
        bit dn;

        m_freq = FMIN;
        m_mod  = SYS / (2 * FMIN);

        repeat (2) @(posedge iCLK);
        #1;
        chk("rst freq", oFREQ, 1);
        chk("rst module", oMODULE, 25000000);
        chk("rst valid", oVALID, 0);
        chk("rst busy", oBUSY, 0);
        @(negedge iCLK); iRST_n = 1'b1;
        @(posedge iCLK); #1;

        run_cmd("up1", 1, 0, 0, 0);
        chk("up1 abs", oMODULE, 12500000);
        run_cmd("dn1", 0, 1, 0, 0);
        run_cmd("up1000", 1, 0, 3, 0);
        chk("up1000 abs", oMODULE, 24975);
        run_cmd("dn_to1000", 0, 1, 0, 0);
        for (int i = 0; i < 8; i++) run_cmd("climb3", 1, 0, 3, 0);
        for (int i = 0; i < 5; i++) run_cmd("climb2", 1, 0, 2, 0);
        chk("at9500", oFREQ, 9500);
        run_cmd("sat_up", 1, 0, 3, 0);
        chk("sat freq", oFREQ, 10000);
        chk("sat module", oMODULE, 2500);
        run_cmd("sat_again", 1, 0, 3, 0);
        run_cmd("drop_while_busy", 0, 1, 3, 3);
        chk("drop freq", oFREQ, 9000);
        run_cmd("both_high", 1, 1, 1, 0);

        // Reset during the division: the pending result must vanish.
        iUP = 1'b1; iSTEP_SEL = 2'd0;
        @(posedge iCLK); #1;
        iUP = 1'b0;
        repeat (11) @(posedge iCLK);
        #1;
        iRST_n = 1'b0;
        #2;
        chk("midrst freq", oFREQ, 1);
        chk("midrst module", oMODULE, 25000000);
        chk("midrst valid", oVALID, 0);
        chk("midrst busy", oBUSY, 0);
        repeat (3) @(posedge iCLK);
        @(negedge iCLK); iRST_n = 1'b1;
        @(posedge iCLK); #1;
        m_freq = FMIN;
        m_mod  = SYS / (2 * FMIN);
        run_cmd("min_dn", 0, 1, 0, 0);
        run_cmd("post_rst_up", 1, 0, 0, 0);
        chk("post_rst abs", oMODULE, 12500000);

        for (int i = 0; i < 20; i++) begin
            r    = $urandom_range(0, 9);
            up   = (r < 5) || (r == 9);
            dn   = (r >= 5);
            sel  = $urandom_range(0, 3);
            drop = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 26) : 0;
            run_cmd("rand", up, dn, sel, drop);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
